// File: rtl/gcd_stim_driver.sv
// 4-phase req/ack initiator: runs a fixed 8-entry operand table through the
// asynchronous GCD core, checks each result, and exposes LED-ready status.
module gcd_stim_driver #(
   parameter int WIDTH       = 8,
   parameter int TIMEOUT     = 1023,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLOCK_50,
   input  logic             KEY,
   input  logic             start,
   input  logic             ack,
   input  logic [WIDTH-1:0] result,
   output logic             req,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] last_result,
   output logic [3:0]       pass_count,
   output logic [3:0]       fail_count,
   output logic             busy,
   output logic             done,
   output logic             timeout_err
);

   localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_REQ_HI, S_CAPTURE, S_REQ_LO, S_NEXT, S_DONE, S_ERR
   } state_t;

   state_t           r_state, w_next;
   logic [SS-1:0]    r_sync;
   logic             w_ack_s;
   logic [TW-1:0]    r_tmo;
   logic [2:0]       r_idx, w_tab_idx;
   logic [WIDTH-1:0] w_tab_a, w_tab_b, w_tab_exp;
   logic [WIDTH-1:0] r_op_a, r_op_b, r_last;
   logic [3:0]       r_pass, r_fail;

   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) r_sync <= '0;
      else      r_sync <= {r_sync[SS-2:0], ack};
   end

   assign w_ack_s = r_sync[SS-1];

   // One table lookup serves both uses: the entry being loaded on the way into
   // SETUP (index 0 from IDLE, index+1 from NEXT) and the expected value in CAPTURE.
   always_comb begin
      w_tab_idx = r_idx;
      if (r_state == S_IDLE)      w_tab_idx = '0;
      else if (r_state == S_NEXT) w_tab_idx = r_idx + 3'd1;
      w_tab_a   = '0;
      w_tab_b   = '0;
      w_tab_exp = '0;
      case (w_tab_idx)
         3'd0: begin w_tab_a = WIDTH'(48);  w_tab_b = WIDTH'(18);  w_tab_exp = WIDTH'(6);  end
         3'd1: begin w_tab_a = WIDTH'(7);   w_tab_b = WIDTH'(5);   w_tab_exp = WIDTH'(1);  end
         3'd2: begin w_tab_a = WIDTH'(100); w_tab_b = WIDTH'(75);  w_tab_exp = WIDTH'(25); end
         3'd3: begin w_tab_a = WIDTH'(255); w_tab_b = WIDTH'(17);  w_tab_exp = WIDTH'(17); end
         3'd4: begin w_tab_a = WIDTH'(64);  w_tab_b = WIDTH'(64);  w_tab_exp = WIDTH'(64); end
         3'd5: begin w_tab_a = WIDTH'(81);  w_tab_b = WIDTH'(27);  w_tab_exp = WIDTH'(27); end
         3'd6: begin w_tab_a = WIDTH'(13);  w_tab_b = WIDTH'(13);  w_tab_exp = WIDTH'(13); end
         default: begin w_tab_a = WIDTH'(200); w_tab_b = WIDTH'(150); w_tab_exp = WIDTH'(50); end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = S_SETUP;
         S_SETUP:   w_next = S_REQ_HI;
         S_REQ_HI: begin
            if (w_ack_s)               w_next = S_CAPTURE;
            else if (r_tmo == TMO_LAST) w_next = S_ERR;
         end
         S_CAPTURE: w_next = S_REQ_LO;
         S_REQ_LO: begin
            if (!w_ack_s)              w_next = S_NEXT;
            else if (r_tmo == TMO_LAST) w_next = S_ERR;
         end
         S_NEXT:    w_next = (r_idx == 3'd7) ? S_DONE : S_SETUP;
         S_DONE:    if (!start) w_next = S_IDLE;
         S_ERR:     w_next = S_ERR;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req         = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      timeout_err = 1'b0;
      case (r_state)
         S_REQ_HI, S_CAPTURE: req = 1'b1;
         S_IDLE:              busy = 1'b0;
         S_DONE:  begin busy = 1'b0; done = 1'b1;        end
         S_ERR:   begin busy = 1'b0; timeout_err = 1'b1; end
         default: ;
      endcase
   end

   // SETUP and CAPTURE always precede the two wait states, so clearing outside
   // the waits is the same as clearing on entry to them.
   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) begin
         r_tmo  <= '0;
         r_idx  <= '0;
         r_op_a <= '0;
         r_op_b <= '0;
         r_last <= '0;
         r_pass <= '0;
         r_fail <= '0;
      end else begin
         if (r_state == S_REQ_HI || r_state == S_REQ_LO) r_tmo <= r_tmo + 1'b1;
         else                                            r_tmo <= '0;
         if (w_next == S_SETUP) begin
            r_idx  <= w_tab_idx;
            r_op_a <= w_tab_a;
            r_op_b <= w_tab_b;
         end
         if (r_state == S_IDLE && start) begin
            r_pass <= '0;
            r_fail <= '0;
         end
         if (r_state == S_CAPTURE) begin
            r_last <= result;
            if (result == w_tab_exp) r_pass <= r_pass + 4'd1;
            else                     r_fail <= r_fail + 4'd1;
         end
      end
   end

   assign op_a        = r_op_a;
   assign op_b        = r_op_b;
   assign last_result = r_last;
   assign pass_count  = r_pass;
   assign fail_count  = r_fail;

endmodule

// File: tb/tb_gcd_stim_driver.sv
// Directed bench for gcd_stim_driver with a behavioural GCD core responder.
module tb_gcd_stim_driver;

   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 1023;

   logic             CLOCK_50 = 1'b0;
   logic             KEY      = 1'b1;
   logic             start    = 1'b0;
   logic             ack      = 1'b0;
   logic [WIDTH-1:0] result   = '0;
   logic             req;
   logic [WIDTH-1:0] op_a, op_b, last_result;
   logic [3:0]       pass_count, fail_count;
   logic             busy, done, timeout_err;

   gcd_stim_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
      .CLOCK_50(CLOCK_50), .KEY(KEY), .start(start), .ack(ack), .result(result),
      .req(req), .op_a(op_a), .op_b(op_b), .last_result(last_result),
      .pass_count(pass_count), .fail_count(fail_count),
      .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int checks   = 0;
   int failures = 0;

   // Core model modes: 0 true GCD, 1 corrupt vector 2, 2 never ack vector 0,
   // 3 never drop ack after vector 4.
   int         m_mode = 0;
   int         m_vec  = 0;
   int         m_st   = 0;
   int         m_cnt  = 0;
   logic [7:0] seen_a [8];
   logic [7:0] seen_b [8];
   logic [7:0] exp_a  [8] = '{8'd48, 8'd7, 8'd100, 8'd255, 8'd64, 8'd81, 8'd13, 8'd200};
   logic [7:0] exp_b  [8] = '{8'd18, 8'd5, 8'd75,  8'd17,  8'd64, 8'd27, 8'd13, 8'd150};

   function automatic logic [7:0] gcd(input logic [7:0] a, input logic [7:0] b);
      int x = a;
      int y = b;
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return 8'(x);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin : core_model
      forever begin
         @(negedge CLOCK_50);
         if (!KEY) begin
            ack = 1'b0; m_st = 0; m_cnt = 0; m_vec = 0;
         end else if (m_st == 0) begin
            if (req) begin
               m_cnt++;
               if (m_cnt >= 3 && !(m_mode == 2 && m_vec == 0)) begin
                  result = gcd(op_a, op_b);
                  if (m_mode == 1 && m_vec == 2) result = result ^ 8'h01;
                  seen_a[m_vec] = op_a;
                  seen_b[m_vec] = op_b;
                  ack   = 1'b1;
                  m_st  = 1;
                  m_cnt = 0;
               end
            end
         end else begin
            if (!req && !(m_mode == 3 && m_vec == 4)) begin
               ack   = 1'b0;
               m_vec = (m_vec + 1) % 8;
               m_st  = 0;
            end
         end
      end
   end

   task automatic do_reset(input int mode);
      KEY   = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      m_mode = mode;
      KEY    = 1'b1;
      @(negedge CLOCK_50);
   endtask

   task automatic wait_done(input string tag);
      int c = 0;
      while (!done && c < 400) begin
         @(negedge CLOCK_50);
         c++;
      end
      chk(tag, done, 1);
   endtask

   task automatic wait_err(input string tag);
      int c = 0;
      while (!timeout_err && c < 2000) begin
         @(negedge CLOCK_50);
         c++;
      end
      chk(tag, timeout_err, 1);
   endtask

   initial begin : stim
      int c;
      // Async reset before any clock edge
      #1 KEY = 1'b0;
      #4;
      chk("rst_req", req, 0);
      chk("rst_op_a", op_a, 0);
      chk("rst_op_b", op_b, 0);
      chk("rst_last", last_result, 0);
      chk("rst_pass", pass_count, 0);
      chk("rst_fail", fail_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_terr", timeout_err, 0);

      // 1: clean run, table order, start-to-req latency
      do_reset(0);
      start = 1'b1;
      @(negedge CLOCK_50);
      chk("t1_setup_busy", busy, 1);
      chk("t1_setup_req", req, 0);
      chk("t1_setup_a", op_a, 48);
      chk("t1_setup_b", op_b, 18);
      @(negedge CLOCK_50);
      chk("t1_req_rise", req, 1);
      wait_done("t1_done");
      chk("t1_pass", pass_count, 8);
      chk("t1_fail", fail_count, 0);
      chk("t1_last", last_result, 50);
      chk("t1_busy", busy, 0);
      chk("t1_req", req, 0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t1_order_a%0d", i), seen_a[i], exp_a[i]);
         chk($sformatf("t1_order_b%0d", i), seen_b[i], exp_b[i]);
      end

      // 6: DONE -> IDLE keeps counts, restart clears and reruns
      start = 1'b0;
      @(negedge CLOCK_50);
      chk("t6_idle_done", done, 0);
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_pass", pass_count, 8);
      chk("t6_idle_last", last_result, 50);
      start = 1'b1;
      @(negedge CLOCK_50);
      chk("t6_clr_pass", pass_count, 0);
      chk("t6_clr_fail", fail_count, 0);
      chk("t6_busy", busy, 1);
      chk("t6_op_a", op_a, 48);
      wait_done("t6_done");
      chk("t6_pass", pass_count, 8);
      chk("t6_fail", fail_count, 0);

      // 2: corrupted result on vector 2
      do_reset(1);
      start = 1'b1;
      wait_done("t2_done");
      chk("t2_pass", pass_count, 7);
      chk("t2_fail", fail_count, 1);
      chk("t2_last", last_result, 50);

      // 3: no ack on vector 0 -> ERR exactly TIMEOUT cycles after REQ_HI entry
      do_reset(2);
      start = 1'b1;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("t3_req_hi", req, 1);
      repeat (TIMEOUT - 1) @(negedge CLOCK_50);
      chk("t3_early_terr", timeout_err, 0);
      chk("t3_early_req", req, 1);
      @(negedge CLOCK_50);
      chk("t3_terr", timeout_err, 1);
      chk("t3_req", req, 0);
      chk("t3_busy", busy, 0);
      start = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      start = 1'b1;
      repeat (5) @(negedge CLOCK_50);
      chk("t3_sticky_terr", timeout_err, 1);
      chk("t3_sticky_busy", busy, 0);
      chk("t3_sticky_req", req, 0);

      // 4: ack stuck high after vector 4 -> ERR from REQ_LO
      do_reset(3);
      start = 1'b1;
      wait_err("t4_terr");
      chk("t4_pass", pass_count, 5);
      chk("t4_fail", fail_count, 0);
      chk("t4_last", last_result, 64);
      chk("t4_req", req, 0);
      chk("t4_done", done, 0);

      // 5: reset during vector 3 handshake, then restart from vector 0
      do_reset(0);
      start = 1'b1;
      c = 0;
      while (!(req && op_a == 8'd255) && c < 200) begin
         @(negedge CLOCK_50);
         c++;
      end
      chk("t5_reach_v3", req && op_a == 8'd255, 1);
      #3 KEY = 1'b0;
      #1;
      chk("t5_async_req", req, 0);
      chk("t5_async_a", op_a, 0);
      chk("t5_async_b", op_b, 0);
      chk("t5_async_last", last_result, 0);
      chk("t5_async_pass", pass_count, 0);
      chk("t5_async_busy", busy, 0);
      start = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      KEY = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b1;
      @(negedge CLOCK_50);
      chk("t5_restart_a", op_a, 48);
      chk("t5_restart_b", op_b, 18);
      chk("t5_restart_req", req, 0);
      wait_done("t5_done");
      chk("t5_pass", pass_count, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
